ir_decode: RTL
==============

# ir_decode

Instruction-register and field-decode stage of the multicycle CPU. It fetches one 32-bit instruction word from instruction memory on request and latches it. It then slices the word into register, function and immediate fields and produces the immediate plus the sign/zero-extend select that drive `NumExtend` (`i_NumExtend_num`, `i_NumExtend_sign`) directly. The decoded bundle is held under a valid/ready handshake until the main controller consumes it.

## Interface
Parameters:
- `RESET_INSTR`, default 32'h0000_0000: value loaded into the IR on reset and on fetch timeout.
- `MEM_TIMEOUT`, default 15: maximum number of FETCH cycles to wait for `mem_valid`. Legal range is 2..255.

Ports. One clock; reset is asynchronous and active-low.
- `i_IrDecode_clk`, in, 1: clock, rising edge.
- `i_IrDecode_rst_n`, in, 1: asynchronous, active-low reset.
- `i_IrDecode_start`, in, 1: request to fetch the next instruction.
- `i_IrDecode_flush`, in, 1: abort the current operation and return to IDLE.
- `o_IrDecode_mem_req`, out, 1: instruction memory read request.
- `i_IrDecode_mem_valid`, in, 1: `mem_rdata` is valid this cycle.
- `i_IrDecode_mem_rdata`, in, 32: instruction word from memory.
- `o_IrDecode_valid`, out, 1: decoded bundle is valid.
- `i_IrDecode_ready`, in, 1: controller accepts the bundle.
- `o_IrDecode_instr`, out, 32: raw IR contents.
- `o_IrDecode_opcode`, out, 6: instr[31:26].
- `o_IrDecode_rs`, out, 5: instr[25:21].
- `o_IrDecode_rt`, out, 5: instr[20:16].
- `o_IrDecode_rd`, out, 5: instr[15:11].
- `o_IrDecode_shamt`, out, 5: instr[10:6].
- `o_IrDecode_funct`, out, 6: instr[5:0].
- `o_IrDecode_imm16`, out, 16: instr[15:0]; feeds `i_NumExtend_num`.
- `o_IrDecode_ext_sign`, out, 1: 1 selects sign-extend, 0 selects zero-extend; feeds `i_NumExtend_sign`.
- `o_IrDecode_jidx`, out, 26: instr[25:0].
- `o_IrDecode_illegal`, out, 1: opcode is not in the supported set.
- `o_IrDecode_timeout`, out, 1: the fetch timed out. Sticky until the next accepted start.
- `o_IrDecode_busy`, out, 1: 1 whenever the state is not IDLE.

## Operation
State machine: IDLE, FETCH, DECODE, HOLD.
- **IDLE**
  - `start`=1 → FETCH. Clear `timeout` and the wait counter.
- **FETCH**
  - `mem_req`=1 for every FETCH cycle.
  - `mem_valid`=1 → IR := `mem_rdata`, next state DECODE.
  - Otherwise the wait counter increments. When the counter reaches `MEM_TIMEOUT`-1 with no `mem_valid`: IR := `RESET_INSTR`, `timeout`:=1, next state DECODE.
- **DECODE**
  - For one cycle, register all field outputs, `ext_sign` and `illegal` from the IR.
  - Next state HOLD.
- **HOLD**
  - `valid`=1. All outputs are stable.
  - `ready`=1 → IDLE. If `start` is also 1 in the same cycle, go straight to FETCH.
- **Flush**
  - `flush`=1 in any state → IDLE at the next edge. `valid` and `mem_req` drop.
  - IR and field outputs keep their values. `timeout` is unchanged.
  - Flush has priority over `mem_valid`, `ready` and `start`.
- `mem_valid` outside FETCH is ignored. `ready` outside HOLD is ignored.
- `ext_sign`=1 for opcodes 0x08 addi, 0x09 addiu, 0x0A slti, 0x0B sltiu, 0x04 beq, 0x05 bne, 0x23 lw, 0x2B sw.
- `ext_sign`=0 for 0x0C andi, 0x0D ori, 0x0E xori, 0x0F lui, 0x00 R-type, 0x02 j, 0x03 jal.
- `illegal`=1 for every other opcode. In that case `ext_sign`=0; fields are still sliced.
- Fields are pure bit slices: no arithmetic, no width change.

## Timing
- Reset (asynchronous, immediate): state IDLE; IR=`RESET_INSTR`.
- Reset values of outputs:
  - 0: `mem_req`, `valid`, `busy`, `timeout`, `illegal`, `ext_sign`.
  - 0: all field outputs.
  - `o_IrDecode_instr`=`RESET_INSTR`.
- Reset asserted mid-operation abandons the fetch or bundle with no further memory request.
- Start latency: `start` sampled at edge t gives `mem_req`=1 from t+1.
- Fetch-to-valid latency: `mem_valid` sampled at edge t gives fields registered at t+1 and `valid`=1 from t+1 until the handshake. Two edges from data to a decoded bundle.
- `mem_valid` in the first FETCH cycle is legal. Minimum start-to-valid is 3 cycles.
- Timeout: `mem_req` stays high for exactly `MEM_TIMEOUT` cycles, then DECODE.
- Handshake completes on an edge with `valid`&`ready`. `valid` is low the following cycle, unless `start` was also high, in which case `mem_req` is high the following cycle.
- Fields change only at the DECODE edge, never while `valid`=1.

## Test plan
- Sign-extended immediate: `start`, `mem_valid` with rdata 0x2109FFF4 → `valid` after 2 edges. Expect opcode=0x08, rs=8, rt=9, imm16=0xFFF4, `ext_sign`=1, `illegal`=0. Downstream `NumExtend` output = 0xFFFFFFF4.
- Zero-extended immediate: rdata 0x3509F234 (ori) → imm16=0xF234, `ext_sign`=0. `NumExtend` output = 0x0000F234.
- R-type: rdata 0x00221820 → rs=1, rt=2, rd=3, shamt=0, funct=0x20, `ext_sign`=0. Then rdata 0xFC000000 → opcode=0x3F, `illegal`=1.
- Backpressure: hold `ready`=0 for 5 cycles in HOLD → `valid` stays 1 and the fields are unchanged. Then `ready`=1 with `start`=1 → `mem_req`=1 on the next cycle.
- Timeout with `MEM_TIMEOUT`=15 and `mem_valid` never asserted → `mem_req` high for 15 cycles; then `instr`=`RESET_INSTR`, `timeout`=1, `valid`=1. The next accepted `start` clears `timeout`.
- Flush and reset:
  - `flush` in FETCH coincident with `mem_valid` → IDLE with `valid`=0 and the IR unchanged.
  - `rst_n` low in HOLD → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/ir_decode_if.sv
`default_nettype none
// ============================================================================
// Module   : ir_decode_if
// Purpose  : Fetch/decode bus between ir_decode, instruction memory and the
//            main controller.
// Revision : 1.0
// ============================================================================
interface ir_decode_if;
    logic        i_IrDecode_start;
    logic        i_IrDecode_flush;
    logic        o_IrDecode_mem_req;
    logic        i_IrDecode_mem_valid;
    logic [31:0] i_IrDecode_mem_rdata;
    logic        o_IrDecode_valid;
    logic        i_IrDecode_ready;
    logic [31:0] o_IrDecode_instr;
    logic [5:0]  o_IrDecode_opcode;
    logic [4:0]  o_IrDecode_rs;
    logic [4:0]  o_IrDecode_rt;
    logic [4:0]  o_IrDecode_rd;
    logic [4:0]  o_IrDecode_shamt;
    logic [5:0]  o_IrDecode_funct;
    logic [15:0] o_IrDecode_imm16;
    logic        o_IrDecode_ext_sign;
    logic [25:0] o_IrDecode_jidx;
    logic        o_IrDecode_illegal;
    logic        o_IrDecode_timeout;
    logic        o_IrDecode_busy;

    modport slave (
        input  i_IrDecode_start, i_IrDecode_flush, i_IrDecode_mem_valid,
               i_IrDecode_mem_rdata, i_IrDecode_ready,
        output o_IrDecode_mem_req, o_IrDecode_valid, o_IrDecode_instr,
               o_IrDecode_opcode, o_IrDecode_rs, o_IrDecode_rt, o_IrDecode_rd,
               o_IrDecode_shamt, o_IrDecode_funct, o_IrDecode_imm16,
               o_IrDecode_ext_sign, o_IrDecode_jidx, o_IrDecode_illegal,
               o_IrDecode_timeout, o_IrDecode_busy
    );

    modport master (
        output i_IrDecode_start, i_IrDecode_flush, i_IrDecode_mem_valid,
               i_IrDecode_mem_rdata, i_IrDecode_ready,
        input  o_IrDecode_mem_req, o_IrDecode_valid, o_IrDecode_instr,
               o_IrDecode_opcode, o_IrDecode_rs, o_IrDecode_rt, o_IrDecode_rd,
               o_IrDecode_shamt, o_IrDecode_funct, o_IrDecode_imm16,
               o_IrDecode_ext_sign, o_IrDecode_jidx, o_IrDecode_illegal,
               o_IrDecode_timeout, o_IrDecode_busy
    );
endinterface
`default_nettype wire

// File: rtl/ir_decode.sv
`default_nettype none
// ============================================================================
// Module   : ir_decode
// Purpose  : Instruction register with fetch timeout, field slicing and
//            immediate-extend select, held under a valid/ready handshake.
// Revision : 1.0
// ============================================================================
module ir_decode #(
    parameter logic [31:0] RESET_INSTR = 32'h0000_0000,
    parameter int          MEM_TIMEOUT = 15
) (
    input  wire logic   i_IrDecode_clk,
    input  wire logic   i_IrDecode_rst_n,
    ir_decode_if.slave  bus
);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_FETCH  = 2'd1;
    localparam logic [1:0] c_S_DECODE = 2'd2;
    localparam logic [1:0] c_S_HOLD   = 2'd3;
    localparam logic [7:0] c_CNT_LAST = 8'(MEM_TIMEOUT - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [7:0]  r_wait_cnt;
    logic [31:0] r_ir;
    logic        r_timeout;
    logic [5:0]  r_opcode;
    logic [4:0]  r_rs, r_rt, r_rd, r_shamt;
    logic [5:0]  r_funct;
    logic [15:0] r_imm16;
    logic [25:0] r_jidx;
    logic        r_ext_sign, r_illegal;

    logic w_mem_req, w_valid, w_busy;
    logic w_start_acc, w_fetch_hit, w_fetch_to, w_fetch_wait;
    logic w_dec_sign, w_dec_illegal;

    // Flush overrides every other event; start is accepted from IDLE or on a
    // completing handshake.
    assign w_start_acc  = !bus.i_IrDecode_flush && bus.i_IrDecode_start &&
                          ((r_state == c_S_IDLE) ||
                           ((r_state == c_S_HOLD) && bus.i_IrDecode_ready));
    assign w_fetch_hit  = (r_state == c_S_FETCH) && !bus.i_IrDecode_flush &&
                          bus.i_IrDecode_mem_valid;
    assign w_fetch_wait = (r_state == c_S_FETCH) && !bus.i_IrDecode_flush &&
                          !bus.i_IrDecode_mem_valid;
    assign w_fetch_to   = w_fetch_wait && (r_wait_cnt == c_CNT_LAST);

    always_ff @(posedge i_IrDecode_clk or negedge i_IrDecode_rst_n) begin
        if (!i_IrDecode_rst_n) r_state <= c_S_IDLE;
        else                   r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.i_IrDecode_flush) begin
            w_state_nxt = c_S_IDLE;
        end else begin
            case (r_state)
                c_S_IDLE:   if (bus.i_IrDecode_start) w_state_nxt = c_S_FETCH;
                c_S_FETCH:  if (w_fetch_hit || w_fetch_to) w_state_nxt = c_S_DECODE;
                c_S_DECODE: w_state_nxt = c_S_HOLD;
                c_S_HOLD:   if (bus.i_IrDecode_ready)
                                w_state_nxt = bus.i_IrDecode_start ? c_S_FETCH : c_S_IDLE;
                default:    w_state_nxt = c_S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_mem_req = (r_state == c_S_FETCH);
        w_valid   = (r_state == c_S_HOLD);
        w_busy    = (r_state != c_S_IDLE);
    end

    always_comb begin
        w_dec_sign    = 1'b0;
        w_dec_illegal = 1'b0;
        case (r_ir[31:26])
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h04, 6'h05, 6'h23, 6'h2B: w_dec_sign = 1'b1;
            6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h00, 6'h02, 6'h03:        w_dec_sign = 1'b0;
            default:                                                w_dec_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge i_IrDecode_clk or negedge i_IrDecode_rst_n) begin
        if (!i_IrDecode_rst_n) begin
            r_wait_cnt <= 8'd0;
            r_ir       <= RESET_INSTR;
            r_timeout  <= 1'b0;
        end else begin
            if (w_start_acc) begin
                r_wait_cnt <= 8'd0;
                r_timeout  <= 1'b0;
            end else if (w_fetch_to) begin
                r_timeout  <= 1'b1;
            end else if (w_fetch_wait) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
            if (w_fetch_hit)     r_ir <= bus.i_IrDecode_mem_rdata;
            else if (w_fetch_to) r_ir <= RESET_INSTR;
        end
    end

    // Fields move only on the DECODE edge so they are frozen while valid is up.
    always_ff @(posedge i_IrDecode_clk or negedge i_IrDecode_rst_n) begin
        if (!i_IrDecode_rst_n) begin
            r_opcode   <= 6'd0;
            r_rs       <= 5'd0;
            r_rt       <= 5'd0;
            r_rd       <= 5'd0;
            r_shamt    <= 5'd0;
            r_funct    <= 6'd0;
            r_imm16    <= 16'd0;
            r_jidx     <= 26'd0;
            r_ext_sign <= 1'b0;
            r_illegal  <= 1'b0;
        end else if ((r_state == c_S_DECODE) && !bus.i_IrDecode_flush) begin
            r_opcode   <= r_ir[31:26];
            r_rs       <= r_ir[25:21];
            r_rt       <= r_ir[20:16];
            r_rd       <= r_ir[15:11];
            r_shamt    <= r_ir[10:6];
            r_funct    <= r_ir[5:0];
            r_imm16    <= r_ir[15:0];
            r_jidx     <= r_ir[25:0];
            r_ext_sign <= w_dec_sign;
            r_illegal  <= w_dec_illegal;
        end
    end

    assign bus.o_IrDecode_mem_req  = w_mem_req;
    assign bus.o_IrDecode_valid    = w_valid;
    assign bus.o_IrDecode_busy     = w_busy;
    assign bus.o_IrDecode_instr    = r_ir;
    assign bus.o_IrDecode_opcode   = r_opcode;
    assign bus.o_IrDecode_rs       = r_rs;
    assign bus.o_IrDecode_rt       = r_rt;
    assign bus.o_IrDecode_rd       = r_rd;
    assign bus.o_IrDecode_shamt    = r_shamt;
    assign bus.o_IrDecode_funct    = r_funct;
    assign bus.o_IrDecode_imm16    = r_imm16;
    assign bus.o_IrDecode_jidx     = r_jidx;
    assign bus.o_IrDecode_ext_sign = r_ext_sign;
    assign bus.o_IrDecode_illegal  = r_illegal;
    assign bus.o_IrDecode_timeout  = r_timeout;

endmodule
`default_nettype wire
